// File: rtl/axis_eth_tx_pad_ts.sv
// TX egress: forwards frames through one output register (1-cycle latency), zero-pads runts, inserts IFG, timestamps SOF.
// Back-pressure: s_axis_tready follows m_axis_tready combinationally in IDLE/DATA; held low while padding and during the gap.
module axis_eth_tx_pad_ts #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_BYTES     = 12,
    parameter int PTP_TS_WIDTH  = 96,
    parameter int PTP_TAG_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [PTP_TAG_WIDTH:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic [PTP_TS_WIDTH-1:0]  ptp_time,
    output logic [PTP_TS_WIDTH-1:0]  m_axis_ptp_ts,
    output logic [PTP_TAG_WIDTH-1:0] m_axis_ptp_ts_tag,
    output logic                     m_axis_ptp_ts_valid
);
    localparam int IFG_RAW    = (IFG_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int IFG_CYCLES = (IFG_RAW < 1) ? 1 : IFG_RAW;
    localparam int IFGW       = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PAD, IFG} state_t;

    state_t                   state;
    logic                     run;
    logic [15:0]              byte_cnt;
    logic [15:0]              pad_left;
    logic [IFGW-1:0]          ifg_cnt;
    logic                     err_q;
    logic                     ts_pending;
    logic [PTP_TAG_WIDTH-1:0] tag_q;

    logic                     out_free, s_fire, m_fire;
    logic [16:0]              pc, base, total, covered;
    logic [15:0]              pad_rem, total_sat;
    logic                     runt, pad_needed;
    logic [KEEP_WIDTH-1:0]    keep_ext, keep_pad;
    logic [DATA_WIDTH-1:0]    data_masked;

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = run && (state == IDLE || state == DATA) && out_free;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;

    always_comb begin
        pc = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) pc = pc + 17'(s_axis_tkeep[i]);
        base       = (state == DATA) ? {1'b0, byte_cnt} : 17'd0;
        total      = base + pc;
        total_sat  = total[16] ? 16'hFFFF : total[15:0];
        covered    = base + 17'(KEEP_WIDTH);
        runt       = (MIN_FRAME_LEN > 0) && (total < 17'(MIN_FRAME_LEN));
        pad_needed = covered < 17'(MIN_FRAME_LEN);
        pad_rem    = 16'(MIN_FRAME_LEN) - covered[15:0];
        keep_ext    = '0;
        keep_pad    = '0;
        data_masked = '0;
        // Runt beat: bytes up to the minimum length become valid; those not supplied read as zero.
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_ext[i] = (base + 17'(i)) < 17'(MIN_FRAME_LEN);
            keep_pad[i] = 16'(i) < pad_left;
            data_masked[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            run                 <= 1'b0;
            byte_cnt            <= '0;
            pad_left            <= '0;
            ifg_cnt             <= '0;
            err_q               <= 1'b0;
            ts_pending          <= 1'b0;
            tag_q               <= '0;
            m_axis_tdata        <= '0;
            m_axis_tkeep        <= '0;
            m_axis_tvalid       <= 1'b0;
            m_axis_tlast        <= 1'b0;
            m_axis_tuser        <= 1'b0;
            m_axis_ptp_ts       <= '0;
            m_axis_ptp_ts_tag   <= '0;
            m_axis_ptp_ts_valid <= 1'b0;
        end else begin
            run                 <= 1'b1;
            m_axis_ptp_ts_valid <= 1'b0;
            if (m_fire) begin
                m_axis_tvalid <= 1'b0;
                if (ts_pending) begin
                    m_axis_ptp_ts       <= ptp_time;
                    m_axis_ptp_ts_tag   <= tag_q;
                    m_axis_ptp_ts_valid <= 1'b1;
                    ts_pending          <= 1'b0;
                end
            end
            case (state)
                IDLE, DATA: if (s_fire) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= s_axis_tdata;
                    m_axis_tkeep  <= s_axis_tkeep;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tuser  <= 1'b0;
                    byte_cnt      <= total_sat;
                    if (state == IDLE) begin
                        tag_q      <= s_axis_tuser[PTP_TAG_WIDTH:1];
                        ts_pending <= 1'b1;
                    end
                    if (!s_axis_tlast) begin
                        state <= DATA;
                    end else if (!runt) begin
                        m_axis_tlast <= 1'b1;
                        m_axis_tuser <= s_axis_tuser[0];
                        ifg_cnt      <= IFGW'(IFG_CYCLES);
                        state        <= IFG;
                    end else begin
                        m_axis_tdata <= data_masked;
                        m_axis_tkeep <= keep_ext;
                        err_q        <= s_axis_tuser[0];
                        if (pad_needed) begin
                            pad_left <= pad_rem;
                            state    <= PAD;
                        end else begin
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= s_axis_tuser[0];
                            ifg_cnt      <= IFGW'(IFG_CYCLES);
                            state        <= IFG;
                        end
                    end
                end
                PAD: if (out_free) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= '0;
                    if (pad_left <= 16'(KEEP_WIDTH)) begin
                        m_axis_tkeep <= keep_pad;
                        m_axis_tlast <= 1'b1;
                        m_axis_tuser <= err_q;
                        ifg_cnt      <= IFGW'(IFG_CYCLES);
                        state        <= IFG;
                    end else begin
                        m_axis_tkeep <= '1;
                        pad_left     <= pad_left - 16'(KEEP_WIDTH);
                    end
                end
                // Gap cycles start counting once the final beat has left the output register.
                IFG: if (!m_axis_tvalid) begin
                    if (ifg_cnt <= IFGW'(1)) state <= IDLE;
                    else ifg_cnt <= ifg_cnt - IFGW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_eth_tx_pad_ts.sv
// Directed bench for axis_eth_tx_pad_ts: a 64-bit and an 8-bit instance share clock, reset and sink ready.
module tb_axis_eth_tx_pad_ts;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [95:0] ptp_time;
    logic        m_tready;
    logic        sel8, stall_mode;
    logic [63:0] src_data;
    logic [7:0]  src_keep;
    logic        src_valid, src_last;
    logic [16:0] src_user;

    logic [63:0] a_m_tdata;  logic [7:0] a_m_tkeep;
    logic        a_tready, a_m_tvalid, a_m_tlast, a_m_tuser, a_tsv;
    logic [95:0] a_ts;       logic [15:0] a_tag;
    logic [7:0]  b_m_tdata;  logic [0:0] b_m_tkeep;
    logic        b_tready, b_m_tvalid, b_m_tlast, b_m_tuser, b_tsv;
    logic [95:0] b_ts;       logic [15:0] b_tag;
    logic        a_valid, b_valid;

    assign a_valid = src_valid && !sel8;
    assign b_valid = src_valid && sel8;

    axis_eth_tx_pad_ts #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(src_data), .s_axis_tkeep(src_keep), .s_axis_tvalid(a_valid),
        .s_axis_tready(a_tready), .s_axis_tlast(src_last), .s_axis_tuser(src_user),
        .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser),
        .ptp_time(ptp_time), .m_axis_ptp_ts(a_ts), .m_axis_ptp_ts_tag(a_tag),
        .m_axis_ptp_ts_valid(a_tsv)
    );

    axis_eth_tx_pad_ts #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(src_data[7:0]), .s_axis_tkeep(src_keep[0:0]), .s_axis_tvalid(b_valid),
        .s_axis_tready(b_tready), .s_axis_tlast(src_last), .s_axis_tuser(src_user),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
        .ptp_time(ptp_time), .m_axis_ptp_ts(b_ts), .m_axis_ptp_ts_tag(b_tag),
        .m_axis_ptp_ts_valid(b_tsv)
    );

    // Outputs of whichever instance is under test, beat packed as {user, last, keep, data}.
    logic        mx_valid, mx_last, mx_sready, mx_tsv;
    logic [73:0] mx_beat;
    logic [95:0] mx_ts;
    logic [15:0] mx_tag;
    assign mx_valid  = sel8 ? b_m_tvalid : a_m_tvalid;
    assign mx_last   = sel8 ? b_m_tlast  : a_m_tlast;
    assign mx_sready = sel8 ? b_tready   : a_tready;
    assign mx_tsv    = sel8 ? b_tsv      : a_tsv;
    assign mx_ts     = sel8 ? b_ts       : a_ts;
    assign mx_tag    = sel8 ? b_tag      : a_tag;
    assign mx_beat   = sel8 ? {b_m_tuser, b_m_tlast, 7'd0, b_m_tkeep, 56'd0, b_m_tdata}
                            : {a_m_tuser, a_m_tlast, a_m_tkeep, a_m_tdata};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bval(input int seed, input int idx);
        return 8'(seed + idx * 13 + 1);
    endfunction

    // Expected output beat j of a frame of len bytes after padding to 60 bytes.
    function automatic logic [73:0] exp_beat(input int len, input bit w8, input int seed,
                                             input bit err, input int j);
        int kw, olen, nb, idx;
        logic [63:0] d;
        logic [7:0]  k;
        kw   = w8 ? 1 : 8;
        olen = (len < 60) ? 60 : len;
        nb   = (olen + kw - 1) / kw;
        d    = '0;
        k    = '0;
        for (int i = 0; i < kw; i++) begin
            idx = j * kw + i;
            if (idx < olen) k[i] = 1'b1;
            if (idx < len)  d[8*i +: 8] = bval(seed, idx);
        end
        return {err && (j == nb - 1), j == nb - 1, k, d};
    endfunction

    logic [73:0] obs_q[$];
    logic [95:0] obs_t[$];
    int          ts_cnt, ifg_low;
    logic [95:0] ts_seen, ts_at;
    logic [15:0] tag_seen;
    bit          got_last, ifg_done;
    int          cur_len, cur_seed;
    bit          cur_w8, cur_err;

    // ptp_time, sink ready and all stimulus change 1 time unit after the rising edge.
    int tick = 0;
    initial begin
        ptp_time = 96'h0000_00AB_0000_0000_0000_1000;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ptp_time = ptp_time + 96'd1;
            tick++;
            m_tready = stall_mode ? tick[0] : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (got_last && !ifg_done) begin
                if (!mx_sready) ifg_low++;
                else ifg_done = 1'b1;
            end
            if (mx_valid && m_tready) begin
                obs_q.push_back(mx_beat);
                obs_t.push_back(ptp_time);
                if (mx_last) got_last = 1'b1;
            end else if (mx_valid) begin
                check($sformatf("stall_hold_b%0d", obs_q.size()), 128'(mx_beat),
                      128'(exp_beat(cur_len, cur_w8, cur_seed, cur_err, obs_q.size())));
            end
            if (mx_tsv) begin
                ts_cnt++;
                ts_seen  = mx_ts;
                tag_seen = mx_tag;
                ts_at    = ptp_time;
            end
        end
    end

    task automatic send_frame(input int len, input int seed, input logic [15:0] tag,
                              input bit err, input int max_beats);
        int kw, nb, idx;
        bit acc;
        kw = sel8 ? 1 : 8;
        nb = (len + kw - 1) / kw;
        for (int j = 0; j < nb && j < max_beats; j++) begin
            for (int i = 0; i < 8; i++) begin
                idx = j * kw + i;
                src_data[8*i +: 8] = (i < kw && idx < len) ? bval(seed, idx) : 8'hA5;
                src_keep[i]        = (i < kw && idx < len);
            end
            src_last  = (j == nb - 1);
            src_user  = {(j == 0) ? tag : 16'hDEAD, err && (j == nb - 1)};
            src_valid = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                @(negedge clk);
                acc = mx_sready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                check("src_accept_timeout", 128'(0), 128'(1));
                break;
            end
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
        src_user  = '0;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_t.delete();
        got_last = 1'b0;
        ifg_done = 1'b0;
        ifg_low  = 0;
        ts_cnt   = 0;
        ts_seen  = '0;
        ts_at    = '0;
        tag_seen = '0;
    endtask

    task automatic run_frame(input bit w8, input int len, input int seed, input logic [15:0] tag,
                             input bit err, input bit stall, input string nm);
        int kw, olen, nb;
        kw   = w8 ? 1 : 8;
        olen = (len < 60) ? 60 : len;
        nb   = (olen + kw - 1) / kw;
        sel8 = w8;
        stall_mode = stall;
        cur_w8 = w8; cur_len = len; cur_seed = seed; cur_err = err;
        clear_obs();
        send_frame(len, seed, tag, err, 1000);
        for (int c = 0; c < 500 && !ifg_done; c++) @(posedge clk);
        #1;
        if (!ifg_done) check({nm, "_done_timeout"}, 128'(0), 128'(1));
        stall_mode = 1'b0;
        check({nm, "_nbeats"}, 128'(obs_q.size()), 128'(nb));
        for (int j = 0; j < nb && j < obs_q.size(); j++)
            check($sformatf("%s_beat%0d", nm, j), 128'(obs_q[j]),
                  128'(exp_beat(len, w8, seed, err, j)));
        check({nm, "_ts_count"}, 128'(ts_cnt), 128'(1));
        check({nm, "_ts_tag"}, 128'(tag_seen), 128'(tag));
        if (obs_t.size() > 0) begin
            check({nm, "_ts_value"}, 128'(ts_seen), 128'(obs_t[0]));
            check({nm, "_ts_cycle"}, 128'(ts_at), 128'(obs_t[0] + 96'd1));
        end
        check({nm, "_ifg_cycles"}, 128'(ifg_low), 128'(w8 ? 12 : 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel8 = 1'b0; stall_mode = 1'b0;
        src_data = '0; src_keep = '0; src_valid = 1'b0; src_last = 1'b0; src_user = '0;
        cur_w8 = 1'b0; cur_len = 64; cur_seed = 0; cur_err = 1'b0;
        clear_obs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl64", 128'({a_m_tvalid, a_m_tlast, a_m_tuser, a_tready, a_tsv}), 128'(0));
        check("reset_data64", 128'({a_m_tkeep, a_m_tdata}), 128'(0));
        check("reset_ts64",   128'({a_tag, a_ts}), 128'(0));
        check("reset_all8",   128'({b_m_tvalid, b_m_tlast, b_m_tuser, b_tready, b_tsv,
                                    b_m_tkeep, b_m_tdata}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        run_frame(1'b0, 64, 16, 16'h1234, 1'b0, 1'b0, "full64");
        run_frame(1'b0, 20, 40, 16'h0A0B, 1'b0, 1'b0, "runt20");
        run_frame(1'b0, 20, 70, 16'h5151, 1'b1, 1'b0, "runt20_err");
        run_frame(1'b0, 57, 90, 16'h7777, 1'b0, 1'b0, "runt57");
        run_frame(1'b0, 64, 33, 16'hC0DE, 1'b0, 1'b1, "stall64");

        // Abort a frame mid-flight, then confirm a clean restart.
        sel8 = 1'b0;
        clear_obs();
        send_frame(64, 85, 16'hBEEF, 1'b0, 4);
        rst = 1'b1;
        ts_cnt = 0;
        @(negedge clk);
        check("midrst_ctrl", 128'({a_m_tvalid, a_m_tlast, a_m_tuser, a_tready, a_tsv}), 128'(0));
        check("midrst_data", 128'({a_m_tkeep, a_m_tdata}), 128'(0));
        check("midrst_ts",   128'({a_tag, a_ts}), 128'(0));
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("midrst_no_ts", 128'(ts_cnt), 128'(0));
        run_frame(1'b0, 64, 119, 16'h4321, 1'b0, 1'b0, "after_rst");

        run_frame(1'b1, 1, 5, 16'h00C8, 1'b0, 1'b0, "w8_runt1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
